// File: rtl/motor_cntrl_nch.sv
// motor_cntrl_nch: N-channel H-bridge driver with sign/magnitude PWM, slew limiting, dead time and global enable.
// Latency: one clock from channel state / PWM counter to the fwd/rev pins; en low brakes the pins two clocks later.
// Backpressure: none; cmd_vld is accepted on any cycle. Define MOTOR_CNTRL_COAST_EN to idle in coast (0/0) instead of brake (1/1).
module motor_cntrl_nch #(
  parameter int NUM_CH    = 2,
  parameter int CMD_W     = 11,
  parameter int SLEW_STEP = 64,
  parameter int DEAD_CYC  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [NUM_CH*CMD_W-1:0]  cmd,
  input  logic                     cmd_vld,
  output logic [NUM_CH-1:0]        fwd,
  output logic [NUM_CH-1:0]        rev,
  output logic                     busy
);

  localparam int PWM_W = CMD_W - 1;
  localparam int DCW   = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

  localparam logic [PWM_W-1:0]        CNT_MAX   = '1;
  localparam logic [DCW-1:0]          DEAD_LOAD = (DEAD_CYC > 0) ? DCW'(DEAD_CYC - 1) : '0;
  localparam logic signed [CMD_W:0]   STEP      = (CMD_W + 1)'(SLEW_STEP);

  typedef enum logic [2:0] {
    ST_BRAKE = 3'd0,
    ST_FWD   = 3'd1,
    ST_REV   = 3'd2,
    ST_DEAD  = 3'd3,
    ST_COAST = 3'd4
  } state_t;

  // Resting state used for a zero command and for en low.
`ifdef MOTOR_CNTRL_COAST_EN
  localparam state_t ST_IDLE = ST_COAST;
`else
  localparam state_t ST_IDLE = ST_BRAKE;
`endif

  logic [PWM_W-1:0]  cnt;
  logic              cnt_wrap;
  logic [NUM_CH-1:0] ch_busy;

  assign cnt_wrap = (cnt == CNT_MAX);

  // Shared free-running PWM counter; one full wrap is one PWM period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + PWM_W'(1);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic signed [CMD_W-1:0] tgt;
    logic signed [CMD_W-1:0] eff;
    logic signed [CMD_W-1:0] eff_nxt;
    logic signed [CMD_W:0]   eff_x;
    logic signed [CMD_W:0]   diff;
    logic        [CMD_W:0]   abs_x;
    logic        [PWM_W-1:0] mag;
    logic                    pwm;
    state_t                  st;
    state_t                  want;
    logic        [DCW-1:0]   dcnt;
    logic                    fwd_q;
    logic                    rev_q;

    // Target register: all channels load together on the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       tgt <= '0;
      else if (cmd_vld) tgt <= cmd[i*CMD_W +: CMD_W];
    end

    // Next slewed command; one extra bit so target-eff never wraps.
    always_comb begin
      eff_x   = {eff[CMD_W-1], eff};
      diff    = {tgt[CMD_W-1], tgt} - eff_x;
      eff_nxt = tgt;
      if (SLEW_STEP > 0) begin
        if (diff > STEP)       eff_nxt = CMD_W'(eff_x + STEP);
        else if (diff < -STEP) eff_nxt = CMD_W'(eff_x - STEP);
      end
    end

    // Effective command moves only at the last count so a new value starts a fresh period.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        eff <= '0;
      else if (!en)      eff <= '0;
      else if (cnt_wrap) eff <= eff_nxt;
    end

    // Magnitude and PWM compare; the most negative command saturates to full scale.
    always_comb begin
      abs_x = eff[CMD_W-1] ? -eff_x : eff_x;
      mag   = (|abs_x[CMD_W:PWM_W]) ? CNT_MAX : abs_x[PWM_W-1:0];
      pwm   = (cnt < mag);
    end

    // Drive mode requested by the current effective command.
    always_comb begin
      if (eff == '0)          want = ST_IDLE;
      else if (eff[CMD_W-1])  want = ST_REV;
      else                    want = ST_FWD;
    end

    // Channel FSM with dead-time insertion; pins are registered from the current state.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st    <= ST_IDLE;
        dcnt  <= '0;
        fwd_q <= 1'b1;
        rev_q <= 1'b1;
      end else begin
        case (st)
          ST_BRAKE: begin fwd_q <= 1'b1; rev_q <= 1'b1; end
          ST_FWD:   begin fwd_q <= pwm;  rev_q <= 1'b0; end
          ST_REV:   begin fwd_q <= 1'b0; rev_q <= pwm;  end
          default:  begin fwd_q <= 1'b0; rev_q <= 1'b0; end
        endcase

        if (!en) begin
          // Disable is an emergency stop: no dead time.
          st <= ST_IDLE;
        end else if (st == ST_DEAD) begin
          // Count is not restarted by eff changes; exit to whatever is wanted now.
          if (dcnt == '0) st <= want;
          else            dcnt <= dcnt - DCW'(1);
        end else if (want != st) begin
          if (DEAD_CYC > 0) begin
            st   <= ST_DEAD;
            dcnt <= DEAD_LOAD;
          end else begin
            st <= want;
          end
        end
      end
    end

    assign fwd[i]     = fwd_q;
    assign rev[i]     = rev_q;
    assign ch_busy[i] = (eff != tgt) || (st == ST_DEAD);
  end

  assign busy = |ch_busy;

endmodule

// File: tb/tb_motor_cntrl_nch.sv
// tb_motor_cntrl_nch: randomized and directed stimulus for motor_cntrl_nch checked cycle by cycle.
// Reference model tracks target/effective command as integers and dead time as a cycle timestamp.
// Pins and busy are compared on every falling edge; reset behaviour is checked asynchronously.
module tb_motor_cntrl_nch;

  localparam int NUM_CH = 2;
  localparam int CMD_W  = 11;
  localparam int PERIOD = 1024;
  localparam int SLEW   = 64;
  localparam int DEAD   = 16;

  localparam int MD_IDLE = 0;
  localparam int MD_FWD  = 1;
  localparam int MD_REV  = 2;
  localparam int MD_DEAD = 3;

`ifdef MOTOR_CNTRL_COAST_EN
  localparam logic IDLE_PIN = 1'b0;
`else
  localparam logic IDLE_PIN = 1'b1;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    en;
  logic [NUM_CH*CMD_W-1:0] cmd;
  logic                    cmd_vld;
  logic [NUM_CH-1:0]       fwd;
  logic [NUM_CH-1:0]       rev;
  logic                    busy;

  motor_cntrl_nch #(
    .NUM_CH   (NUM_CH),
    .CMD_W    (CMD_W),
    .SLEW_STEP(SLEW),
    .DEAD_CYC (DEAD)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .cmd    (cmd),
    .cmd_vld(cmd_vld),
    .fwd    (fwd),
    .rev    (rev),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Reference state: values as they should stand after the most recent rising edge.
  int                m_cnt;
  int                m_cyc;
  int                m_tgt  [NUM_CH];
  int                m_eff  [NUM_CH];
  int                m_mode [NUM_CH];
  int                m_dend [NUM_CH];
  logic [NUM_CH-1:0] m_fwd;
  logic [NUM_CH-1:0] m_rev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_cyc = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_tgt[i]  = 0;
      m_eff[i]  = 0;
      m_mode[i] = MD_IDLE;
      m_dend[i] = 0;
    end
    m_fwd = '1;
    m_rev = '1;
  endtask

  function automatic logic m_busy();
    logic b;
    b = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (m_eff[i] != m_tgt[i] || m_mode[i] == MD_DEAD) b = 1'b1;
    return b;
  endfunction

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    int   mag;
    int   want;
    int   d;
    logic pwm;
    for (int i = 0; i < NUM_CH; i++) begin
      mag = (m_eff[i] < 0) ? -m_eff[i] : m_eff[i];
      if (mag > PERIOD - 1) mag = PERIOD - 1;
      pwm = (m_cnt < mag);
      case (m_mode[i])
        MD_IDLE: begin m_fwd[i] = IDLE_PIN; m_rev[i] = IDLE_PIN; end
        MD_FWD:  begin m_fwd[i] = pwm;      m_rev[i] = 1'b0;     end
        MD_REV:  begin m_fwd[i] = 1'b0;     m_rev[i] = pwm;      end
        default: begin m_fwd[i] = 1'b0;     m_rev[i] = 1'b0;     end
      endcase

      want = (m_eff[i] == 0) ? MD_IDLE : ((m_eff[i] > 0) ? MD_FWD : MD_REV);
      if (!en) begin
        m_mode[i] = MD_IDLE;
      end else if (m_mode[i] == MD_DEAD) begin
        if (m_cyc >= m_dend[i]) m_mode[i] = want;
      end else if (want != m_mode[i]) begin
        if (DEAD > 0) begin
          m_mode[i] = MD_DEAD;
          m_dend[i] = m_cyc + DEAD;
        end else begin
          m_mode[i] = want;
        end
      end

      if (!en) begin
        m_eff[i] = 0;
      end else if (m_cnt == PERIOD - 1) begin
        d = m_tgt[i] - m_eff[i];
        if (SLEW == 0 || (d <= SLEW && d >= -SLEW)) m_eff[i] = m_tgt[i];
        else m_eff[i] = m_eff[i] + ((d > 0) ? SLEW : -SLEW);
      end

      if (cmd_vld) m_tgt[i] = int'($signed(cmd[i*CMD_W +: CMD_W]));
    end
    m_cnt = (m_cnt + 1) % PERIOD;
    m_cyc++;
  endtask

  // One clock: update the model, let the DUT clock, compare on the falling edge.
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("fwd", 32'(fwd), 32'(m_fwd));
    chk("rev", 32'(rev), 32'(m_rev));
    chk("busy", 32'(busy), 32'(m_busy()));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic set_cmd(input int c0, input int c1);
    logic [CMD_W-1:0] a;
    logic [CMD_W-1:0] b;
    a   = CMD_W'(c0);
    b   = CMD_W'(c1);
    cmd = {b, a};
  endtask

  task automatic strobe(input int c0, input int c1);
    set_cmd(c0, c1);
    cmd_vld = 1'b1;
    step();
    cmd_vld = 1'b0;
  endtask

  task automatic wait_cnt(input int n);
    for (int k = 0; k < PERIOD && m_cnt != n; k++) step();
  endtask

  function automatic int rand_cmd();
    case ($urandom_range(0, 7))
      0:       return -1024;
      1:       return 1023;
      2:       return 0;
      default: return int'($urandom_range(0, 2047)) - 1024;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b1;
    en      = 1'b0;
    cmd     = '0;
    cmd_vld = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_fwd", 32'(fwd), 32'(2'b11));
    chk("rst_rev", 32'(rev), 32'(2'b11));
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    en    = 1'b1;

    // Idle with zero command for three periods.
    run(3 * PERIOD);

    // Slew ch0 up to +256 with dead time before FWD.
    strobe(256, 0);
    run(5 * PERIOD);

    // Down to +128, then reverse through zero.
    strobe(128, 0);
    run(3 * PERIOD);
    strobe(-128, 0);
    run(5 * PERIOD);

    // Full-scale negative on ch1 and +512 on ch0.
    strobe(512, -1024);
    run(17 * PERIOD);

    // Enable dropped mid-period, then restored.
    wait_cnt(PERIOD / 2 + 7);
    en = 1'b0;
    run(37);
    en = 1'b1;
    run(9 * PERIOD);

    // Random commands and enable drops.
    for (int k = 0; k < 8000; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        set_cmd(rand_cmd(), rand_cmd());
        cmd_vld = 1'b1;
      end
      if (en && $urandom_range(0, 1999) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 19) == 0) en = 1'b1;
      step();
      cmd_vld = 1'b0;
    end

    // Asynchronous reset while ch0 is in dead time.
    en = 1'b0;
    run(2);
    en = 1'b1;
    strobe(300, 0);
    for (int k = 0; k < 2 * PERIOD && m_mode[0] != MD_DEAD; k++) step();
    run(5);
    chk("dead_seen", 32'(m_mode[0]), 32'(MD_DEAD));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_fwd", 32'(fwd), 32'(2'b11));
    chk("arst_rev", 32'(rev), 32'(2'b11));
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    strobe(0, 100);
    run(3 * PERIOD);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
